// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// State encoding and Booth digit layout.
package booth_multiplier_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = MULT_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } digit_t;

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle of the multiplier.
// The master starts operations; the slave returns results.
interface booth_multiplier_if
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  ctrl_MULT,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY
  );

endinterface

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: window -> digit and addend.
// Addend is WIDTH+2 bits so that -2 * most-negative fits.
module booth_recode
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       win,
  output digit_t           digit,
  output logic [WIDTH+1:0] addend
);

  logic [WIDTH+1:0] ax;
  logic [WIDTH+1:0] mag;

  assign ax = {{2{a[WIDTH-1]}}, a};

  // Decode the three-bit window into a signed digit.
  always_comb begin
    digit = '{neg: 1'b0, two: 1'b0, one: 1'b0};
    unique case (1'b1)
      (win == 3'b001),
      (win == 3'b010):
        digit = '{neg: 1'b0, two: 1'b0, one: 1'b1};
      (win == 3'b011):
        digit = '{neg: 1'b0, two: 1'b1, one: 1'b0};
      (win == 3'b100):
        digit = '{neg: 1'b1, two: 1'b1, one: 1'b0};
      (win == 3'b101),
      (win == 3'b110):
        digit = '{neg: 1'b1, two: 1'b0, one: 1'b1};
      default:
        digit = '{neg: 1'b0, two: 1'b0, one: 1'b0};
    endcase
  end

  // Select magnitude, then negate for negative digits.
  always_comb begin
    mag = '0;
    if (digit.two)
      mag = ax << 1;
    else if (digit.one)
      mag = ax;
    addend = digit.neg ? -mag : mag;
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-4 Booth multiplier.
// Fixed 17-edge latency from start to result-ready pulse.
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  booth_multiplier_if.slave bus
);

  localparam int ITERS = WIDTH / 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH+1:0] acc;
  logic [WIDTH:0]   mreg;
  logic [WIDTH-1:0] res;
  logic             exc;
  logic             rdy;

  digit_t             digit;
  logic [WIDTH+1:0]   addend;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH+1:0]   acc_nx;
  logic [WIDTH:0]     mreg_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     hi;

  booth_recode #(
    .WIDTH (WIDTH)
  ) u_recode (
    .a      (areg),
    .win    (mreg[2:0]),
    .digit  (digit),
    .addend (addend)
  );

  assign sum     = acc + addend;
  assign acc_nx  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
  assign mreg_nx = {sum[1:0], mreg[WIDTH:2]};
  assign prod    = {acc[WIDTH-1:0], mreg[WIDTH:1]};
  assign hi      = prod[2*WIDTH-1:WIDTH-1];

  assign bus.data_result    = res;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state: a start wins in every state.
  always_comb begin
    state_nx = state;
    if (bus.ctrl_MULT) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        RUN:  if (cnt == LAST) state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand latch, Booth iterations and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      areg <= '0;
      acc  <= '0;
      mreg <= '0;
      res  <= '0;
      exc  <= 1'b0;
      rdy  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (bus.ctrl_MULT) begin
        areg <= bus.data_operandA;
        mreg <= {bus.data_operandB, 1'b0};
        acc  <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        acc  <= acc_nx;
        mreg <= mreg_nx;
        cnt  <= cnt + CW'(1);
      end else if (state == DONE) begin
        res <= prod[WIDTH-1:0];
        exc <= ~((&hi) | ~(|hi));
        rdy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier.
// Table-driven products plus restart/reset/back-to-back sequences.
module tb_booth_multiplier;
  import booth_multiplier_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  booth_multiplier_if bus ();

  booth_multiplier dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string name, input logic [31:0] hold);
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.data_resultRDY) break;
      if (bus.data_result !== hold) bad++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd17);
    chk({name, "_hold"}, 64'(bad), 64'd0);
  endtask

  initial begin
    vec_t        vecs[11];
    logic [31:0] hold;
    int          seen;

    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{32'h00010000, 32'h00008000, 32'h80000000, 1'b1};
    vecs[2]  = '{32'h00007FFF, 32'h00010000, 32'h7FFF0000, 1'b0};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[4]  = '{32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h00000000, 32'h12345678, 32'h00000000, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    vecs[9]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1};
    vecs[10] = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0};

    rst_n             = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #12;
    chk("reset_result", 64'(bus.data_result), 64'd0);
    chk("reset_exc", 64'(bus.data_exception), 64'd0);
    chk("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    hold = 32'd0;
    for (int i = 0; i < 11; i++) begin
      start(vecs[i].a, vecs[i].b);
      wait_rdy("vec", hold);
      chk("vec_result", 64'(bus.data_result), 64'(vecs[i].res));
      chk("vec_exc", 64'(bus.data_exception), 64'(vecs[i].exc));
      @(negedge clk);
      chk("vec_rdy_drop", 64'(bus.data_resultRDY), 64'd0);
      hold = vecs[i].res;
    end

    // Restart mid-run: 5x5 aborted by 3x4 at E8.
    start(32'd5, 32'd5);
    seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.data_resultRDY) seen++;
      if (bus.data_result !== hold) seen++;
    end
    chk("abort_early", 64'(seen), 64'd0);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    wait_rdy("abort", hold);
    chk("abort_result", 64'(bus.data_result), 64'd12);
    chk("abort_exc", 64'(bus.data_exception), 64'd0);
    hold = 32'd12;

    // Asynchronous reset between E10 and E11.
    start(32'd9, 32'd9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset_result", 64'(bus.data_result), 64'd0);
    chk("areset_exc", 64'(bus.data_exception), 64'd0);
    chk("areset_rdy", 64'(bus.data_resultRDY), 64'd0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_resultRDY) seen++;
    end
    chk("areset_no_rdy", 64'(seen), 64'd0);
    start(32'd6, 32'd7);
    wait_rdy("post_reset", 32'd0);
    chk("post_reset_result", 64'(bus.data_result), 64'd42);

    // Back-to-back: start in the RDY cycle of 2x3.
    start(32'd2, 32'd3);
    wait_rdy("b2b_first", 32'd42);
    chk("b2b_first_result", 64'(bus.data_result), 64'd6);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'hFFFFFFFE;
    bus.data_operandB = 32'hFFFFFFFE;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    chk("b2b_rdy_drop", 64'(bus.data_resultRDY), 64'd0);
    wait_rdy("b2b_second", 32'd6);
    chk("b2b_second_result", 64'(bus.data_result), 64'd4);
    chk("b2b_second_exc", 64'(bus.data_exception), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
